counter_sched: RTL and testbench

Round-robin scheduler that shares one 5-bit loadable up-counter (`count`/`data`/`load`/`enable` interface) between NREQ requesters. Each requester asks for a timed interval of `len` enabled counter cycles. The scheduler grants one requester at a time, loads the counter and enables it until terminal count. It then reports completion. It sits between the requesting control blocks and a single counter instance, and is the only driver of that counter's `load`, `enable` and `data`.

---
 rtl/counter_sched.sv | 166 ++++++++++++++++
 tb/tb_counter_sched.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sched.sv
// counter_sched: round-robin arbiter that hands one shared loadable up-counter
// to one requester at a time for a timed interval of `len` enabled cycles.
//
// Handshake: a requester raises `req[i]` with `req_len` slice i valid and
// holds it until it sees `done` or `abort` with `done_id == i`. Dropping
// `req[i]` while granted (LOAD or RUN) gives up the interval and produces an
// `abort` pulse. `done` and `abort` are single-cycle pulses qualified by
// `done_id`. `gnt` is one-hot from LOAD through DONE and zero otherwise.
module counter_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 5,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_len,
    output logic [NREQ-1:0]       gnt,
    output logic                  done,
    output logic                  abort,
    output logic [IDW-1:0]        done_id,
    output logic                  cnt_load,
    output logic                  cnt_enable,
    output logic [WIDTH-1:0]      cnt_data,
    input  logic [WIDTH-1:0]      cnt_count,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    state_t           state_q, state_d;
    logic [IDW-1:0]   winner_q, winner_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [WIDTH-1:0] len_q, len_d;

    logic [NREQ-1:0]  gnt_d;
    logic             done_d, abort_d, cnt_load_d, cnt_enable_d;
    logic [IDW-1:0]   done_id_d;
    logic [WIDTH-1:0] cnt_data_d;

    logic [IDW-1:0]   pick;
    logic             pick_valid;
    logic [WIDTH-1:0] pick_len;
    logic [WIDTH-1:0] count_after;

    assign state_dbg = state_q;

    // Round-robin search: first set request bit starting just above last grant.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            int k;
            k = (int'(last_q) + i) % NREQ;
            if (!pick_valid && req[k]) begin
                pick_valid = 1'b1;
                pick       = IDW'(k);
            end
        end
        pick_len = req_len[int'(pick)*WIDTH +: WIDTH];
    end

    // Counter value after the coming edge; enable is registered, so we look one step ahead.
    assign count_after = cnt_count + WIDTH'(cnt_enable);

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        last_d       = last_q;
        len_d        = len_q;
        gnt_d        = gnt;
        done_d       = 1'b0;
        abort_d      = 1'b0;
        done_id_d    = done_id;
        cnt_load_d   = 1'b0;
        cnt_enable_d = 1'b0;
        cnt_data_d   = cnt_data;

        unique case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (pick_valid) begin
                    winner_d   = pick;
                    last_d     = pick;
                    len_d      = pick_len;
                    gnt_d      = NREQ'(1) << pick;
                    cnt_load_d = 1'b1;
                    cnt_data_d = ~pick_len;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                if (!req[winner_q]) begin
                    abort_d   = 1'b1;
                    done_id_d = winner_q;
                    gnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    // Zero-length interval: the counter is loaded at all-ones already.
                    cnt_enable_d = (len_q != '0);
                    state_d      = RUN;
                end
            end
            RUN: begin
                if (!req[winner_q]) begin
                    abort_d   = 1'b1;
                    done_id_d = winner_q;
                    gnt_d     = '0;
                    state_d   = IDLE;
                end else if (cnt_count == ALL_ONES) begin
                    done_d    = 1'b1;
                    done_id_d = winner_q;
                    state_d   = DONE;
                end else begin
                    cnt_enable_d = (count_after != ALL_ONES);
                end
            end
            DONE: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any interval without a pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            winner_q   <= '0;
            last_q     <= IDW'(NREQ - 1);
            len_q      <= '0;
            gnt        <= '0;
            done       <= 1'b0;
            abort      <= 1'b0;
            done_id    <= '0;
            cnt_load   <= 1'b0;
            cnt_enable <= 1'b0;
            cnt_data   <= '0;
        end else begin
            state_q    <= state_d;
            winner_q   <= winner_d;
            last_q     <= last_d;
            len_q      <= len_d;
            gnt        <= gnt_d;
            done       <= done_d;
            abort      <= abort_d;
            done_id    <= done_id_d;
            cnt_load   <= cnt_load_d;
            cnt_enable <= cnt_enable_d;
            cnt_data   <= cnt_data_d;
        end
    end

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: models the shared counter, keeps an expected queue
// of completions/aborts, and checks grant order, timing and counter values.
module tb_counter_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 5;
    localparam int IDW   = $clog2(NREQ);

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_len;
    logic [NREQ-1:0]       gnt;
    logic                  done;
    logic                  abort;
    logic [IDW-1:0]        done_id;
    logic                  cnt_load;
    logic                  cnt_enable;
    logic [WIDTH-1:0]      cnt_data;
    logic [WIDTH-1:0]      cnt_count;
    logic [1:0]            state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int en_cnt   = 0;
    int load_cyc = 0;

    // entry: {is_abort, id[2:0], len[4:0]}
    logic [8:0] exp_q[$];

    counter_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_len    (req_len),
        .gnt        (gnt),
        .done       (done),
        .abort      (abort),
        .done_id    (done_id),
        .cnt_load   (cnt_load),
        .cnt_enable (cnt_enable),
        .cnt_data   (cnt_data),
        .cnt_count  (cnt_count),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // shared loadable up-counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             cnt_count <= '0;
        else if (cnt_load)   cnt_count <= cnt_data;
        else if (cnt_enable) cnt_count <= cnt_count + 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] mk(input logic ab, input int id, input int len);
        return {ab, 3'(id), 5'(len)};
    endfunction

    // driver tasks
    task automatic set_len(input int i, input int v);
        req_len[i*WIDTH +: WIDTH] = WIDTH'(v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_load(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cnt_load && n < budget);
        if (!cnt_load) check("timeout_load", 32'(cnt_load), 32'd1);
        load_cyc = cyc;
    endtask

    task automatic wait_end(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(done || abort) && n < budget);
        if (!(done || abort)) check("timeout_end", 32'(done | abort), 32'd1);
    endtask

    // scoreboard: pop on every done/abort pulse
    initial begin
        forever begin
            @(negedge clk);
            if (cnt_load) en_cnt = 0;
            else if (cnt_enable) en_cnt++;
            if (done || abort) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected", 32'({done, abort}), 32'd0);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("sb_kind", 32'(abort), 32'(e[8]));
                    check("sb_excl", 32'(done & abort), 32'd0);
                    check("sb_id", 32'(done_id), 32'(e[7:5]));
                    if (!e[8]) begin
                        check("sb_len", 32'(en_cnt), 32'(e[4:0]));
                        check("sb_gnt_done", 32'(gnt), 32'(1) << e[7:5]);
                    end else begin
                        check("sb_gnt_abort", 32'(gnt), 32'd0);
                    end
                end
            end
        end
    end

    initial begin
        rst     = 1'b1;
        req     = '0;
        req_len = '0;
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_abort", 32'(abort), 32'd0);
        check("rst_id", 32'(done_id), 32'd0);
        check("rst_load", 32'(cnt_load), 32'd0);
        check("rst_en", 32'(cnt_enable), 32'd0);
        check("rst_data", 32'(cnt_data), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        do_reset();

        // single request, len 3
        set_len(0, 3);
        req = 4'b0001;
        exp_q.push_back(mk(1'b0, 0, 3));
        wait_load(10);
        check("t1_gnt", 32'(gnt), 32'b0001);
        check("t1_data", 32'(cnt_data), 32'h1C);
        @(negedge clk);
        check("t1_load_pulse", 32'(cnt_load), 32'd0);
        check("t1_count_loaded", 32'(cnt_count), 32'h1C);
        wait_end(20);
        check("t1_latency", 32'(cyc - load_cyc), 32'd5);
        check("t1_count_end", 32'(cnt_count), 32'h1F);
        req = '0;
        @(negedge clk);
        check("t1_gnt_clear", 32'(gnt), 32'd0);
        check("t1_done_pulse", 32'(done), 32'd0);

        // round robin, full contention, len 1
        do_reset();
        for (int i = 0; i < NREQ; i++) set_len(i, 1);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) exp_q.push_back(mk(1'b0, k % 4, 1));
        for (int k = 0; k < 5; k++) begin
            int prev;
            prev = load_cyc;
            wait_load(20);
            check("rr_gnt", 32'(gnt), 32'(1) << (k % 4));
            if (k > 0) check("rr_period", 32'(load_cyc - prev), 32'd5);
        end
        wait_end(20);
        req = '0;
        @(negedge clk);

        // zero length on requester 1 (last grant was 0)
        set_len(1, 0);
        req = 4'b0010;
        exp_q.push_back(mk(1'b0, 1, 0));
        wait_load(10);
        check("len0_gnt", 32'(gnt), 32'b0010);
        check("len0_data", 32'(cnt_data), 32'h1F);
        wait_end(10);
        check("len0_latency", 32'(cyc - load_cyc), 32'd2);
        req = '0;
        @(negedge clk);

        // max length on requester 2
        set_len(2, 31);
        req = 4'b0100;
        exp_q.push_back(mk(1'b0, 2, 31));
        wait_load(10);
        check("len31_data", 32'(cnt_data), 32'h00);
        wait_end(100);
        check("len31_count_end", 32'(cnt_count), 32'h1F);
        req = '0;
        @(negedge clk);
        check("len31_no_wrap", 32'(cnt_count), 32'h1F);

        // abort: requester 1 len 10, requester 2 pending
        set_len(1, 10);
        set_len(2, 2);
        req = 4'b0110;
        exp_q.push_back(mk(1'b1, 1, 0));
        exp_q.push_back(mk(1'b0, 2, 2));
        wait_load(10);
        check("ab_gnt", 32'(gnt), 32'b0010);
        repeat (4) @(negedge clk);
        check("ab_count_pre", 32'(cnt_count), 32'h18);
        req = 4'b0100;
        @(negedge clk);
        check("ab_abort", 32'(abort), 32'd1);
        check("ab_done", 32'(done), 32'd0);
        check("ab_id", 32'(done_id), 32'd1);
        check("ab_en", 32'(cnt_enable), 32'd0);
        @(negedge clk);
        check("ab_count_hold", 32'(cnt_count), 32'h19);
        check("ab_next_gnt", 32'(gnt), 32'b0100);
        wait_end(20);
        req = '0;
        @(negedge clk);

        // reset in the middle of RUN
        set_len(0, 20);
        req = 4'b0001;
        wait_load(10);
        repeat (3) @(negedge clk);
        check("mr_en_pre", 32'(cnt_enable), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mr_gnt", 32'(gnt), 32'd0);
        check("mr_en", 32'(cnt_enable), 32'd0);
        check("mr_outs", 32'({done, abort, cnt_load, done_id, cnt_data}), 32'd0);
        req = 4'b1010;
        set_len(1, 2);
        repeat (2) @(negedge clk);
        exp_q.push_back(mk(1'b0, 1, 2));
        rst = 1'b0;
        wait_load(10);
        check("mr_first_gnt", 32'(gnt), 32'b0010);
        wait_end(20);
        req = '0;
        @(negedge clk);

        // req_len change during RUN is ignored
        set_len(0, 2);
        req = 4'b0001;
        exp_q.push_back(mk(1'b0, 0, 2));
        wait_load(10);
        @(negedge clk);
        set_len(0, 7);
        wait_end(20);
        req = '0;
        repeat (3) @(negedge clk);

        check("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
